// File: rtl/adc_pkt_pkg.sv
// Shared types and constants for the ADC sample packetizer.
//   pkt_state_t  : packetizer FSM state; names the byte currently held in the output register
//   HDR0_DEF/HDR1_DEF : default header bytes
//   DROP_W       : width of the dropped-sample counter
//   frame_bytes  : total bytes in a frame for a given samples-per-frame value
package adc_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H0,
    ST_H1,
    ST_SEQ,
    ST_PAY,
    ST_CSUM
  } pkt_state_t;

  localparam logic [7:0] HDR0_DEF = 8'hA5;
  localparam logic [7:0] HDR1_DEF = 8'h5A;
  localparam int         DROP_W   = 16;

  // header(2) + seq(1) + checksum(1) + two samples packed into three bytes
  function automatic int frame_bytes(input int spf);
    return 4 + (3 * spf) / 2;
  endfunction

endpackage

// File: rtl/adc_sample_queue.sv
// Small synchronous show-ahead FIFO that absorbs UART backpressure.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push/i_din : write request and data; ignored while full unless i_pop is also high
//   i_pop        : read request; advances the head
//   o_dout       : head entry (valid when !o_empty)
//   o_empty/o_full : occupancy flags
module adc_sample_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == FULL_CNT);
  assign o_dout  = r_mem[r_rd];

  // When full, a simultaneous pop frees the slot the write lands in.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/adc_sample_packetizer.sv
// Packs a 12-bit ADC sample stream into UART byte frames:
//   HDR0 HDR1 SEQ payload(3 bytes per sample pair) CSUM(XOR of SEQ and payload).
// Ports:
//   I_clk, I_rst                 : clock, synchronous active-high reset
//   I_sample_valid, I_sample     : unstallable sample stream
//   I_byte_ready                 : UART TX accepts O_byte this cycle
//   O_byte_valid, O_byte         : registered byte output
//   O_frame_start, O_frame_end   : first/last byte markers, qualified by O_byte_valid
//   O_seq                        : sequence number of the current or next frame
//   O_drop_cnt                   : saturating count of samples lost to a full queue
//
// state | meaning (byte held in the output register)
// IDLE  | nothing in flight, waiting for a queued sample
// H0    | HDR0
// H1    | HDR1
// SEQ   | sequence byte
// PAY   | payload byte (or stalled waiting for a sample)
// CSUM  | checksum byte
module adc_sample_packetizer
  import adc_pkt_pkg::*;
#(
  parameter int         SAMPLES_PER_FRAME = 64,
  parameter int         QUEUE_DEPTH       = 4,
  parameter logic [7:0] HDR0              = HDR0_DEF,
  parameter logic [7:0] HDR1              = HDR1_DEF
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_sample_valid,
  input  logic [11:0]       I_sample,
  input  logic              I_byte_ready,
  output logic              O_byte_valid,
  output logic [7:0]        O_byte,
  output logic              O_frame_start,
  output logic              O_frame_end,
  output logic [7:0]        O_seq,
  output logic [DROP_W-1:0] O_drop_cnt
);

  localparam int            PAY_BYTES = frame_bytes(SAMPLES_PER_FRAME) - 4;
  localparam int            PW        = $clog2(PAY_BYTES + 1);
  localparam logic [PW-1:0] PAY_LAST  = PW'(PAY_BYTES);

  pkt_state_t    r_state;
  logic [1:0]    r_phase;
  logic [PW-1:0] r_pay_cnt;
  logic [3:0]    r_s0_lo;
  logic [7:0]    r_s1_lo;
  logic [7:0]    r_csum;

  logic [11:0]   w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_load;
  logic          w_want_pay;
  logic          w_pay_ok;
  logic          w_pop;
  logic          w_drop;
  logic [7:0]    w_pay_byte;

  adc_sample_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (12)
  ) u_queue (
    .i_clk   (I_clk),
    .i_rst   (I_rst),
    .i_push  (I_sample_valid),
    .i_pop   (w_pop),
    .i_din   (I_sample),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_load     = !O_byte_valid || I_byte_ready;
  assign w_want_pay = (r_state == ST_SEQ) || ((r_state == ST_PAY) && (r_pay_cnt != PAY_LAST));
  // Phase 2 emits the latched low byte of s1 and never needs the queue.
  assign w_pay_ok   = (r_phase == 2'd2) || !w_empty;
  assign w_pop      = w_load && w_want_pay && (r_phase != 2'd2) && !w_empty;
  assign w_drop     = I_sample_valid && w_full && !w_pop;

  always_comb begin
    w_pay_byte = r_s1_lo;
    case (r_phase)
      2'd0:    w_pay_byte = w_head[11:4];
      2'd1:    w_pay_byte = {r_s0_lo, w_head[11:8]};
      default: w_pay_byte = r_s1_lo;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state       <= ST_IDLE;
      r_phase       <= '0;
      r_pay_cnt     <= '0;
      r_s0_lo       <= '0;
      r_s1_lo       <= '0;
      r_csum        <= '0;
      O_byte_valid  <= 1'b0;
      O_byte        <= '0;
      O_frame_start <= 1'b0;
      O_frame_end   <= 1'b0;
      O_seq         <= '0;
      O_drop_cnt    <= '0;
    end else begin
      if (w_drop && (O_drop_cnt != '1)) O_drop_cnt <= O_drop_cnt + 1'b1;

      if (w_load) begin
        // Anything not reloaded below leaves the register empty.
        O_byte_valid  <= 1'b0;
        O_frame_start <= 1'b0;
        O_frame_end   <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (!w_empty) begin
              O_byte        <= HDR0;
              O_byte_valid  <= 1'b1;
              O_frame_start <= 1'b1;
              r_csum        <= '0;
              r_state       <= ST_H0;
            end
          end
          ST_H0: begin
            O_byte       <= HDR1;
            O_byte_valid <= 1'b1;
            r_state      <= ST_H1;
          end
          ST_H1: begin
            O_byte       <= O_seq;
            O_byte_valid <= 1'b1;
            r_csum       <= O_seq;
            r_pay_cnt    <= '0;
            r_phase      <= '0;
            r_state      <= ST_SEQ;
          end
          ST_SEQ, ST_PAY: begin
            if (w_want_pay) begin
              if (w_pay_ok) begin
                O_byte       <= w_pay_byte;
                O_byte_valid <= 1'b1;
                r_csum       <= r_csum ^ w_pay_byte;
                r_pay_cnt    <= r_pay_cnt + 1'b1;
                r_phase      <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
                if (r_phase == 2'd0) r_s0_lo <= w_head[3:0];
                if (r_phase == 2'd1) r_s1_lo <= w_head[7:0];
                r_state      <= ST_PAY;
              end
            end else begin
              O_byte       <= r_csum;
              O_byte_valid <= 1'b1;
              O_frame_end  <= 1'b1;
              r_state      <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            // Checksum is always valid here, so w_load means it was accepted.
            O_seq   <= O_seq + 8'd1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_packetizer.sv
module tb_adc_sample_packetizer;
  import adc_pkt_pkg::*;

  localparam int SPF = 4;
  localparam int QD  = 4;
  localparam int FB  = frame_bytes(SPF);

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_sample_valid = 1'b0;
  logic [11:0] I_sample = '0;
  logic        I_byte_ready = 1'b0;
  logic        O_byte_valid;
  logic [7:0]  O_byte;
  logic        O_frame_start;
  logic        O_frame_end;
  logic [7:0]  O_seq;
  logic [15:0] O_drop_cnt;

  always #5 I_clk = ~I_clk;

  adc_sample_packetizer #(
    .SAMPLES_PER_FRAME (SPF),
    .QUEUE_DEPTH       (QD),
    .HDR0              (8'hA5),
    .HDR1              (8'h5A)
  ) dut (
    .I_clk          (I_clk),
    .I_rst          (I_rst),
    .I_sample_valid (I_sample_valid),
    .I_sample       (I_sample),
    .I_byte_ready   (I_byte_ready),
    .O_byte_valid   (O_byte_valid),
    .O_byte         (O_byte),
    .O_frame_start  (O_frame_start),
    .O_frame_end    (O_frame_end),
    .O_seq          (O_seq),
    .O_drop_cnt     (O_drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: list of accepted samples and position within the frame.
  logic [11:0] smp[$];
  logic [7:0]  got[$];
  int          base, pos, pushed, hs_pops, exp_drop, frames_done;
  logic [7:0]  m_seq, m_csum, seq_seen;
  logic        prev_hold;
  logic [9:0]  prev_out;

  function automatic logic [11:0] smp_at(input int idx);
    if (idx < smp.size()) return smp[idx];
    return 12'hxxx;
  endfunction

  function automatic logic [7:0] model_byte();
    int k;
    logic [11:0] s0, s1;
    if (pos == 0) return 8'hA5;
    if (pos == 1) return 8'h5A;
    if (pos == 2) return m_seq;
    if (pos == FB - 1) return m_csum;
    k  = pos - 3;
    s0 = smp_at(base + 2 * (k / 3));
    s1 = smp_at(base + 2 * (k / 3) + 1);
    case (k % 3)
      0:       return s0[11:4];
      1:       return {s0[3:0], s1[11:8]};
      default: return s1[7:0];
    endcase
  endfunction

  task automatic model_clear();
    smp.delete();
    base = 0; pos = 0; pushed = 0; hs_pops = 0; exp_drop = 0;
    m_seq = 8'h00; m_csum = 8'h00; prev_hold = 1'b0;
  endtask

  task automatic step(input logic sv, input logic [11:0] sd, input logic rdy);
    logic [7:0] e;
    @(negedge I_clk);
    if (prev_hold) begin
      check_eq("hold_valid", O_byte_valid, 1'b1);
      check_eq("hold_data", {O_frame_start, O_frame_end, O_byte}, prev_out);
    end
    if (O_byte_valid && rdy) begin
      e = model_byte();
      check_eq("byte", O_byte, e);
      check_eq("sof", O_frame_start, pos == 0);
      check_eq("eof", O_frame_end, pos == FB - 1);
      got.push_back(O_byte);
      if (pos == 2) begin
        check_eq("o_seq", O_seq, m_seq);
        seq_seen = O_byte;
        m_csum   = m_seq;
      end else if (pos > 2 && pos < FB - 1) begin
        m_csum ^= e;
        if ((pos - 3) % 3 != 2) hs_pops++;
      end
      pos++;
      if (pos == FB) begin
        pos = 0; m_seq++; base += SPF; frames_done++;
      end
    end
    prev_hold = O_byte_valid && !rdy;
    prev_out  = {O_frame_start, O_frame_end, O_byte};
    if (sv) begin
      if (pushed - hs_pops < QD) begin
        smp.push_back(sd);
        pushed++;
      end else begin
        exp_drop++;
      end
    end
    I_sample_valid = sv;
    I_sample       = sd;
    I_byte_ready   = rdy;
  endtask

  task automatic do_reset();
    @(negedge I_clk);
    I_rst = 1'b1; I_sample_valid = 1'b0; I_byte_ready = 1'b0;
    model_clear();
    @(negedge I_clk);
    I_rst = 1'b0;
    check_eq("rst_valid", O_byte_valid, 1'b0);
    check_eq("rst_byte", O_byte, 8'h00);
    check_eq("rst_flags", {O_frame_start, O_frame_end}, 2'b00);
    check_eq("rst_seq", O_seq, 8'h00);
    check_eq("rst_drop", O_drop_cnt, 16'h0000);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 12'h000, rdy);
  endtask

  logic [11:0] t_smp[4];
  logic [7:0]  vec[10];

  task automatic set_vec(input logic [7:0] s);
    vec[0] = 8'hA5; vec[1] = 8'h5A; vec[2] = s;
    vec[3] = 8'h12; vec[4] = 8'h34; vec[5] = 8'h56;
    vec[6] = 8'h78; vec[7] = 8'h9A; vec[8] = 8'hBC;
    vec[9] = s ^ 8'h2E;
  endtask

  task automatic cmp_got(input string tag, input int n);
    check_eq({tag, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) check_eq(tag, got[i], vec[i]);
  endtask

  initial begin
    int c, sent;
    frames_done = 0;
    seq_seen    = 8'h00;
    t_smp[0] = 12'h123; t_smp[1] = 12'h456; t_smp[2] = 12'h789; t_smp[3] = 12'hABC;
    do_reset();

    // 1: back-to-back samples, ready high, with HDR0 latency check
    got.delete();
    step(1'b1, t_smp[0], 1'b1);
    step(1'b1, t_smp[1], 1'b1);
    check_eq("lat_n1_valid", O_byte_valid, 1'b0);
    step(1'b1, t_smp[2], 1'b1);
    check_eq("lat_n2_valid", O_byte_valid, 1'b1);
    check_eq("lat_n2_byte", O_byte, 8'hA5);
    step(1'b1, t_smp[3], 1'b1);
    idle(20, 1'b1);
    set_vec(8'h00);
    cmp_got("t1", 10);
    check_eq("t1_seq", O_seq, 8'h01);
    check_eq("t1_idle", O_byte_valid, 1'b0);

    // 2: ready toggling every cycle
    got.delete();
    for (int i = 0; i < 4; i++) step(1'b1, t_smp[i], i % 2 == 0);
    for (int i = 0; i < 40; i++) step(1'b0, 12'h000, i % 2 == 1);
    set_vec(8'h01);
    cmp_got("t2", 10);

    // 3: ready low, queue overflows
    got.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 12'h100 + 12'(i), 1'b0);
    idle(3, 1'b0);
    check_eq("t3_held_byte", O_byte, 8'hA5);
    check_eq("t3_held_valid", O_byte_valid, 1'b1);
    check_eq("t3_drop", O_drop_cnt, 16'd6);
    check_eq("t3_drop_model", O_drop_cnt, exp_drop);
    idle(30, 1'b1);
    check_eq("t3_len", got.size(), FB);
    check_eq("t3_pay0", got[3], 8'h10);

    // 4: stall for a missing sample
    got.delete();
    for (int i = 0; i < 3; i++) step(1'b1, t_smp[i], 1'b1);
    idle(20, 1'b1);
    set_vec(8'h03);
    cmp_got("t4a", 7);
    check_eq("t4_stalled", O_byte_valid, 1'b0);
    step(1'b1, t_smp[3], 1'b1);
    idle(15, 1'b1);
    cmp_got("t4b", 10);

    // 6: reset in the payload of the third frame
    frames_done = 0;
    c = 0;
    while (!(frames_done == 2 && pos >= 5) && c < 400) begin
      step(c % 4 == 0, 12'($urandom), 1'b1);
      c++;
    end
    check_eq("t6_reached", (frames_done == 2 && pos >= 5), 1'b1);
    do_reset();

    // 5: 257 frames from seq 0, samples every 4th cycle
    got.delete();
    frames_done = 0;
    sent = 0;
    for (int i = 0; i < 5000; i++) begin
      if (i % 4 == 0 && sent < 257 * SPF) begin
        step(1'b1, 12'($urandom), 1'b1);
        sent++;
      end else begin
        step(1'b0, 12'h000, 1'b1);
      end
    end
    idle(30, 1'b1);
    check_eq("t5_frames", frames_done, 257);
    check_eq("t5_seq257", seq_seen, 8'h00);
    check_eq("t5_drop", O_drop_cnt, 16'h0000);
    set_vec(8'h00);
    for (int i = 0; i < 3; i++) check_eq("t6_newframe", got[i], vec[i]);

    // random traffic with random backpressure and one reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step(($urandom_range(0, 2) == 0) && (pushed - hs_pops < QD),
           12'($urandom), $urandom_range(0, 3) != 0);
    end
    idle(60, 1'b1);
    check_eq("rand_drop", O_drop_cnt, exp_drop);
    check_eq("rand_seq", O_seq, m_seq);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_sample_packetizer.md
Name: adc_sample_packetizer

Overview:
Consumes the 12-bit sample stream emitted on the read-clock side of the ADC sample FIFO. That stream has a valid strobe and no backpressure. The block packs samples into byte frames for the high-speed UART transmitter: header, sequence number, packed payload and XOR checksum. A small internal queue absorbs UART backpressure. Samples arriving while the queue is full are dropped and counted.

Parameters:
SAMPLES_PER_FRAME, 64, samples per frame; must be even and ≥2.
QUEUE_DEPTH, 4, sample queue depth; must be a power of 2 and ≥2.
HDR0, 8'hA5, first header byte.
HDR1, 8'h5A, second header byte.

Ports:
I_clk  in  1  single clock (UART-side clock, same domain as the FIFO read side).
I_rst  in  1  synchronous, active-high reset.
I_sample_valid  in  1  sample strobe; cannot be stalled.
I_sample  in  12  sample data, qualified by I_sample_valid.
I_byte_ready  in  1  UART TX can accept O_byte this cycle.
O_byte_valid  out  1  O_byte is valid.
O_byte  out  8  frame byte.
O_frame_start  out  1  high with the HDR0 byte; qualified by O_byte_valid.
O_frame_end  out  1  high with the checksum byte; qualified by O_byte_valid.
O_seq  out  8  sequence number of the current or next frame.
O_drop_cnt  out  16  count of dropped samples; saturates at 16'hFFFF.

Behaviour:
- Reset (synchronous, I_rst=1):
  - Outputs: O_byte_valid=0, O_byte=0, O_frame_start=0, O_frame_end=0, O_seq=0, O_drop_cnt=0.
  - Internal: queue emptied, FSM=IDLE, checksum=0, payload counters=0.
  - A partial frame is discarded silently; no O_frame_end is emitted for it.
- Queue:
  - Push on I_sample_valid when the queue is not full.
  - Sample dropped when I_sample_valid=1, queue full and no pop this cycle; O_drop_cnt increments.
  - Push and pop in the same cycle while full: push is accepted, no drop.
- Output register:
  - O_byte, O_byte_valid, O_frame_start and O_frame_end are registered.
  - The register loads when !O_byte_valid || I_byte_ready.
  - While O_byte_valid=1 and I_byte_ready=0, all four outputs hold stable.
- FSM states: IDLE, H0, H1, SEQ, PAY, CSUM. One byte is loaded per handshake.
  - IDLE → H0 when the queue is non-empty.
  - H0 → H1 → SEQ → PAY, then CSUM after SAMPLES_PER_FRAME*3/2 payload bytes.
  - CSUM → IDLE. O_seq increments mod 256 on the checksum handshake.
  - Header and SEQ bytes pop nothing.
- PAY byte phase p, cycling 0→1→2, for sample pair s0, s1:
  - p0: byte = head[11:4]. Needs queue non-empty. On load, pop and latch s0[3:0].
  - p1: byte = {s0[3:0], head[11:8]}. Needs queue non-empty. On load, pop and latch s1[7:0].
  - p2: byte = s1[7:0]. Always loadable.
  - If the queue is empty in p0 or p1, no byte is loaded: O_byte_valid drops after the pending handshake. The FSM stalls in place with no timeout.
- Checksum: XOR of the SEQ byte and all payload bytes. Cleared on entry to H0.
- Latency: with the block idle and the queue empty, a sample pushed at cycle n gives O_byte_valid=1 with HDR0 at cycle n+2.
- Frame length: 4 + 3*SAMPLES_PER_FRAME/2 bytes.

Decomposition:
- Package adc_pkt_pkg:
  - FSM state enum.
  - HDR0/HDR1 defaults.
  - Function frame_bytes(spf).
  - Drop-counter width constant (16).
- Sub-module adc_sample_queue: synchronous FIFO, 12-bit wide, QUEUE_DEPTH deep.
  - Ports: push, pop, din, dout (head, show-ahead), empty, full.
  - Push while full is ignored unless pop is also asserted.

Test Plan:
1. SPF=4, I_byte_ready=1, samples 0x123, 0x456, 0x789, 0xABC on consecutive cycles → bytes A5 5A 00 12 34 56 78 9A BC 2E. O_frame_start only on A5, O_frame_end only on 2E, then O_seq=01.
2. Same stimulus, I_byte_ready toggling 1/0 every cycle → identical byte sequence. O_byte is stable whenever valid=1 and ready=0; no duplicated or lost bytes.
3. SPF=4, QUEUE_DEPTH=4, I_byte_ready=0, 10 consecutive samples → O_byte=A5 held, O_drop_cnt=6. After ready=1, the frame carries the first 4 samples.
4. SPF=4, send 0x123, 0x456, 0x789 only → 7 bytes (A5 5A 00 12 34 56 78), then O_byte_valid=0. Send 0xABC 20 cycles later → 9A BC 2E follow.
5. Run 257 complete frames → SEQ byte of frame 257 is 00 (mod-256 wrap); no drops with ready=1 and samples every 4th cycle.
6. Assert I_rst for 1 cycle mid-payload of frame 3 → next cycle all outputs at reset values, O_seq=0. The next sample starts a new frame with A5 5A 00.
